// File: rtl/ac_motor_multiphase_bridge_if.sv
// Bridge bus: carrier/reference samples and control in, gate drives out.
interface ac_motor_multiphase_bridge_if #(
  parameter int unsigned PHASES     = 3,
  parameter int unsigned BITS       = 12,
  parameter int unsigned LEVEL_BITS = 12,
  parameter int unsigned DT_BITS    = 8
);
  localparam int unsigned W = BITS + LEVEL_BITS;

  logic                  ENABLE;
  logic                  DIR;
  logic [DT_BITS-1:0]    DEAD_TIME;
  logic [W-1:0]          TRIANGLE;
  logic [PHASES*W-1:0]   SINE;
  logic [PHASES-1:0]     OUT_HI;
  logic [PHASES-1:0]     OUT_LO;
  logic [PHASES-1:0]     EN;

  modport master (
    output ENABLE, DIR, DEAD_TIME, TRIANGLE, SINE,
    input  OUT_HI, OUT_LO, EN
  );

  modport slave (
    input  ENABLE, DIR, DEAD_TIME, TRIANGLE, SINE,
    output OUT_HI, OUT_LO, EN
  );
endinterface

// File: rtl/ac_motor_multiphase_bridge.sv
// Multi-phase sine/triangle PWM comparator with per-channel half-bridge
// drive and break-before-make dead time.
module ac_motor_multiphase_bridge #(
  parameter int unsigned PHASES     = 3,
  parameter int unsigned BITS       = 12,
  parameter int unsigned LEVEL_BITS = 12,
  parameter int unsigned DT_BITS    = 8
) (
  input logic CLK,
  input logic RESET,
  ac_motor_multiphase_bridge_if.slave bridge
);
  localparam int unsigned W = BITS + LEVEL_BITS;

  typedef enum logic [1:0] {ST_OFF, ST_DEAD, ST_HIGH, ST_LOW} state_t;

  logic signed [W-1:0]  tri_r;
  logic [PHASES*W-1:0]  sine_r;
  logic                 dir_r;
  logic                 enable_r;
  logic [PHASES-1:0]    en_r;
  logic [PHASES-1:0]    dem_r;

  state_t               state_q  [PHASES];
  state_t               state_nx [PHASES];
  logic [DT_BITS-1:0]   cnt_q    [PHASES];
  logic [DT_BITS-1:0]   cnt_nx   [PHASES];
  logic [PHASES-1:0]    tgt_q, tgt_nx;
  logic [PHASES-1:0]    hi_r, lo_r, hi_nx, lo_nx;
  logic [DT_BITS-1:0]   dt_eff;

  // A programmed dead time of zero still yields one dead cycle
  assign dt_eff = (bridge.DEAD_TIME == '0) ? DT_BITS'(1) : bridge.DEAD_TIME;

  // Stage 1: register carrier, references and controls; EN follows enable_r
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tri_r    <= '0;
      sine_r   <= '0;
      dir_r    <= 1'b0;
      enable_r <= 1'b0;
      en_r     <= '0;
    end else begin
      tri_r    <= bridge.TRIANGLE;
      sine_r   <= bridge.SINE;
      dir_r    <= bridge.DIR;
      enable_r <= bridge.ENABLE;
      en_r     <= {PHASES{enable_r}};
    end
  end

  // Stage 2: per-channel side demand, signed compare then direction swap
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dem_r <= '0;
    end else begin
      for (int unsigned i = 0; i < PHASES; i++) begin
        dem_r[i] <= ($signed(sine_r[i*W +: W]) > tri_r) ^ dir_r;
      end
    end
  end

  // Stage 3 state register; gates are registered alongside the state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < PHASES; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
      tgt_q <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
    end else begin
      for (int unsigned i = 0; i < PHASES; i++) begin
        state_q[i] <= state_nx[i];
        cnt_q[i]   <= cnt_nx[i];
      end
      tgt_q <= tgt_nx;
      hi_r  <= hi_nx;
      lo_r  <= lo_nx;
    end
  end

  // Stage 3 next-state: disable wins, every side change goes through DEAD
  always_comb begin
    tgt_nx = tgt_q;
    for (int unsigned i = 0; i < PHASES; i++) begin
      state_nx[i] = state_q[i];
      cnt_nx[i]   = cnt_q[i];
      if (!enable_r) begin
        state_nx[i] = ST_OFF;
      end else begin
        case (state_q[i])
          ST_OFF: begin
            state_nx[i] = ST_DEAD;
            tgt_nx[i]   = dem_r[i];
            cnt_nx[i]   = dt_eff;
          end
          ST_DEAD: begin
            if (dem_r[i] != tgt_q[i]) begin
              tgt_nx[i] = dem_r[i];
              cnt_nx[i] = dt_eff;
            end else if (cnt_q[i] == DT_BITS'(1)) begin
              state_nx[i] = tgt_q[i] ? ST_HIGH : ST_LOW;
            end else begin
              cnt_nx[i] = cnt_q[i] - DT_BITS'(1);
            end
          end
          ST_HIGH: begin
            if (!dem_r[i]) begin
              state_nx[i] = ST_DEAD;
              tgt_nx[i]   = 1'b0;
              cnt_nx[i]   = dt_eff;
            end
          end
          ST_LOW: begin
            if (dem_r[i]) begin
              state_nx[i] = ST_DEAD;
              tgt_nx[i]   = 1'b1;
              cnt_nx[i]   = dt_eff;
            end
          end
          default: state_nx[i] = ST_OFF;
        endcase
      end
    end
  end

  // Stage 3 outputs: decode the next state so gates register with it
  always_comb begin
    hi_nx = '0;
    lo_nx = '0;
    for (int unsigned i = 0; i < PHASES; i++) begin
      hi_nx[i] = (state_nx[i] == ST_HIGH);
      lo_nx[i] = (state_nx[i] == ST_LOW);
    end
  end

  assign bridge.OUT_HI = hi_r;
  assign bridge.OUT_LO = lo_r;
  assign bridge.EN     = en_r;
endmodule
